lmac_regrd_arbiter: RTL
=======================

# lmac_regrd_arbiter

Read-path controller for the LMAC register port: shares the single-outstanding `host_addr_reg` / `reg_rd_start` / `reg_rd_done_out` / `FMAC_REGDOUT` interface of `vlmac` between two requesters, such as the host register bridge and the statistics poller. It arbitrates round-robin, sequences one read at a time, and returns data or a timeout error to the winning requester. It sits between the requesters and `vlmac`, in the same `clk` domain.

## Interface
- `TIMEOUT`, 1024: WAIT-state cycles without `reg_rd_done_out` before the read is failed.
- `ERR_DATA`, 32'hDEAD_BEEF: `rdata` value returned on timeout.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`  in  1  requester 0 read request; held until `req0_ready`.
- `req0_addr`  in  16  requester 0 register address; stable while `req0_valid` is high.
- `req0_ready`  out  1  request accepted this cycle (combinational).
- `req0_rvalid`  out  1  one-cycle response strobe.
- `req0_rdata`  out  32  response data; valid with `req0_rvalid`.
- `req0_rerr`  out  1  timeout flag; valid with `req0_rvalid`.
- `req1_valid`, `req1_addr`, `req1_ready`, `req1_rvalid`, `req1_rdata`, `req1_rerr`: same as requester 0.
- `host_addr_reg`  out  16  register address to the MAC.
- `reg_rd_start`  out  1  one-cycle read start pulse to the MAC.
- `reg_rd_done_out`  in  1  MAC read completion.
- `FMAC_REGDOUT`  in  32  MAC read data; sampled when `reg_rd_done_out` is high.
- `busy`  out  1  high in every state except IDLE.
- `timeout_cnt`  out  8  saturating count of timed-out reads.

## Operation
- State machine:
  - IDLE → START on accept.
  - START → WAIT unconditionally.
  - WAIT → RESP on done or timeout.
  - RESP → IDLE unconditionally.
- Arbitration in IDLE:
  - One valid requester is granted.
  - Both valid: the requester not recorded in `last_grant` is granted.
  - `last_grant` updates on each accept and resets to 1, so req0 wins the first tie.
  - `reqN_ready` = IDLE & grant==N. At most one ready per cycle, never outside IDLE.
- Accept: latch the address into `host_addr_reg` and the granted index. `host_addr_reg` holds that value until the next accept.
- START: `reg_rd_start`=1 for exactly this cycle. The wait counter clears.
- WAIT:
  - `reg_rd_done_out` is sampled only in WAIT; done in IDLE, START or RESP is ignored (stale).
  - Done=1: capture `FMAC_REGDOUT`, rerr=0, go to RESP.
  - Done=0 and counter==TIMEOUT-1: data=ERR_DATA, rerr=1, `timeout_cnt` increments (saturates at 255), go to RESP.
  - Otherwise the counter increments.
  - Done coinciding with expiry: done wins, no error is counted.
- RESP:
  - `reqN_rvalid`=1 for one cycle to the granted requester only; the other requester's rvalid stays 0.
  - rdata/rerr are held until the next response, so they are valid at least in the rvalid cycle.
- Counter width: $clog2(TIMEOUT+1).
- Reset, asynchronous (including mid-read):
  - State goes to IDLE and `last_grant`=1.
  - All outputs go to 0, including `host_addr_reg`, rdata, `timeout_cnt` and `busy`.
  - An in-flight read is dropped with no rvalid, and a late done is ignored.

## Timing
- Accept at cycle 0 → `reg_rd_start` at cycle 1 → WAIT from cycle 2.
- Done at cycle k (k≥2) → rvalid at k+1.
- Minimum accept-to-rvalid latency: 3 cycles.
- Timeout: WAIT cycles 2..TIMEOUT+1 with no done → rvalid+rerr at cycle TIMEOUT+2.
- Next accept no earlier than the cycle after RESP. Back-to-back reads take 4 cycles minimum each.
- Combinational paths: only `reqN_valid` → `reqN_ready`. All MAC-side outputs are registered.

## Test plan
- Single read: req0 addr 16'h0010, MAC returns done 3 cycles after start with 32'h1234_5678 → `reg_rd_start` pulse at cycle 1 with `host_addr_reg`=16'h0010; `req0_rvalid` at cycle 5, rdata=32'h1234_5678, rerr=0; req1 outputs idle.
- Contention: both valid from reset with addrs 16'h0020 / 16'h0030, held valid → grants alternate req0, req1, req0; each ready lasts one cycle; responses are routed to the matching requester.
- Timeout: TIMEOUT=8, done never asserts → rvalid at cycle 10 with rdata=32'hDEAD_BEEF, rerr=1, `timeout_cnt`=1; then 256 further timeouts → `timeout_cnt` stays 255.
- Boundary: done in the last WAIT cycle (counter==TIMEOUT-1) → rerr=0, MAC data returned, `timeout_cnt` unchanged. Done pulsed in IDLE or START → ignored, no rvalid.
- Reset mid-WAIT: assert `rst_n`=0 during WAIT, release, then assert a late done → no rvalid, `busy`=0, all outputs 0; a next tie is won by req0.

Source files
------------

// File: rtl/lmac_regrd_arbiter.sv
// -----------------------------------------------------------------------------
// lmac_regrd_arbiter
//
// Shares the single-outstanding register read port of the LMAC between two
// requesters (e.g. host register bridge and statistics poller). Requests are
// arbitrated round-robin. One read is sequenced at a time: address latch,
// start pulse, wait for completion or timeout, then a one-cycle response to
// the winning requester.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid / reqN_addr          request from requester N (held until ready)
//   reqN_ready                      request accepted this cycle (combinational)
//   reqN_rvalid/_rdata/_rerr        one-cycle response; data/err held until the
//                                   next response to that requester
//   host_addr_reg, reg_rd_start     registered address and start pulse to MAC
//   reg_rd_done_out, FMAC_REGDOUT   completion and read data from MAC
//   busy                            high whenever the FSM is not idle
//   timeout_cnt                     saturating count of timed-out reads
// -----------------------------------------------------------------------------
module lmac_regrd_arbiter #(
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_addr,
  output logic        req0_ready,
  output logic        req0_rvalid,
  output logic [31:0] req0_rdata,
  output logic        req0_rerr,
  input  logic        req1_valid,
  input  logic [15:0] req1_addr,
  output logic        req1_ready,
  output logic        req1_rvalid,
  output logic [31:0] req1_rdata,
  output logic        req1_rerr,
  output logic [15:0] host_addr_reg,
  output logic        reg_rd_start,
  input  logic        reg_rd_done_out,
  input  logic [31:0] FMAC_REGDOUT,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic [15:0]   host_addr_q, host_addr_d;
  logic          rd_start_q, rd_start_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]    timeout_cnt_q, timeout_cnt_d;

  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic          any_valid;
  logic          grant;
  logic          accept;

  // Response produced when leaving WAIT; routed per requester below.
  logic          resp_fire;
  logic [31:0]   resp_data;
  logic          resp_err;

  logic [1:0]    rvalid_o;
  logic [1:0]    rerr_o;
  logic [31:0]   rdata_o [2];

  assign req_valid = {req1_valid, req0_valid};
  assign any_valid = |req_valid;

  // On a tie the requester that did not win last time is granted; with a
  // single requester valid, that one is granted (index of the valid bit).
  assign grant  = (req_valid == 2'b11) ? ~last_grant_q : ~req_valid[0];
  assign accept = (state_q == S_IDLE) && any_valid;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gnt_d         = gnt_q;
    host_addr_d   = host_addr_q;
    rd_start_d    = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    resp_fire     = 1'b0;
    resp_data     = FMAC_REGDOUT;
    resp_err      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d      = S_START;
          gnt_d        = grant;
          last_grant_d = grant;
          host_addr_d  = grant ? req1_addr : req0_addr;
          // Registered start pulse: high exactly during the START cycle.
          rd_start_d   = 1'b1;
        end
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Completion is checked first so a done on the final wait cycle
        // still returns MAC data rather than an error.
        if (reg_rd_done_out) begin
          resp_fire = 1'b1;
          resp_data = FMAC_REGDOUT;
          state_d   = S_RESP;
        end else if (wait_cnt_q == CNT_LAST) begin
          resp_fire = 1'b1;
          resp_data = ERR_DATA;
          resp_err  = 1'b1;
          if (timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
          state_d   = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      gnt_q         <= 1'b0;
      host_addr_q   <= '0;
      rd_start_q    <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gnt_q         <= gnt_d;
      host_addr_q   <= host_addr_d;
      rd_start_q    <= rd_start_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  // Per-requester ready and response registers. Data/err of a requester are
  // only overwritten by a response addressed to that requester.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic        rvalid_q, rvalid_d;
    logic        rerr_q, rerr_d;
    logic [31:0] rdata_q, rdata_d;

    assign req_ready[gi] = accept && (grant == 1'(gi));

    always_comb begin
      rvalid_d = resp_fire && (gnt_q == 1'(gi));
      rdata_d  = rdata_q;
      rerr_d   = rerr_q;
      if (rvalid_d) begin
        rdata_d = resp_data;
        rerr_d  = resp_err;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_q <= 1'b0;
        rerr_q   <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rvalid_d;
        rerr_q   <= rerr_d;
        rdata_q  <= rdata_d;
      end
    end

    assign rvalid_o[gi] = rvalid_q;
    assign rerr_o[gi]   = rerr_q;
    assign rdata_o[gi]  = rdata_q;
  end

  assign req0_ready    = req_ready[0];
  assign req1_ready    = req_ready[1];
  assign req0_rvalid   = rvalid_o[0];
  assign req1_rvalid   = rvalid_o[1];
  assign req0_rdata    = rdata_o[0];
  assign req1_rdata    = rdata_o[1];
  assign req0_rerr     = rerr_o[0];
  assign req1_rerr     = rerr_o[1];
  assign host_addr_reg = host_addr_q;
  assign reg_rd_start  = rd_start_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_cnt   = timeout_cnt_q;

endmodule
